// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad column scanner with whole-frame debounce and single-cycle key events.
// Optional auto-repeat while a key stays held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scan_ctrl #(
  parameter int COL_DWELL_CYCLES    = 50_000,
  parameter int DEBOUNCE_FRAMES     = 3,
  parameter int REPEAT_DELAY_FRAMES = 125,
  parameter int REPEAT_RATE_FRAMES  = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       multi_key
);

  localparam int DW = (COL_DWELL_CYCLES > 2) ? $clog2(COL_DWELL_CYCLES) : 1;
  localparam int SW = (DEBOUNCE_FRAMES > 1) ? $clog2(DEBOUNCE_FRAMES + 1) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(COL_DWELL_CYCLES - 1);
  localparam logic [SW-1:0] DEB_MAX    = SW'(DEBOUNCE_FRAMES);

  if (COL_DWELL_CYCLES < 4 || DEBOUNCE_FRAMES < 1 ||
      REPEAT_DELAY_FRAMES < 1 || REPEAT_RATE_FRAMES < 1) begin : g_bad_param
    $error("keypad_scan_ctrl: parameter below legal minimum");
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY_FRAMES > REPEAT_RATE_FRAMES) ?
                        REPEAT_DELAY_FRAMES : REPEAT_RATE_FRAMES;
  localparam int RW   = $clog2(RMAX + 1);
`endif

  typedef enum logic [0:0] {IDLE_WAIT = 1'b0, HELD = 1'b1} state_t;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: key_map = 4'h1;  4'h1: key_map = 4'h2;  4'h2: key_map = 4'h3;  4'h3: key_map = 4'hA;
      4'h4: key_map = 4'h4;  4'h5: key_map = 4'h5;  4'h6: key_map = 4'h6;  4'h7: key_map = 4'hB;
      4'h8: key_map = 4'h7;  4'h9: key_map = 4'h8;  4'hA: key_map = 4'h9;  4'hB: key_map = 4'hC;
      4'hC: key_map = 4'h0;  4'hD: key_map = 4'hF;  4'hE: key_map = 4'hE;  4'hF: key_map = 4'hD;
      default: key_map = 4'h0;
    endcase
  endfunction

  function automatic logic [2:0] zero_count(input logic [3:0] r);
    zero_count = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (!r[i]) zero_count = zero_count + 3'd1;
    end
  endfunction

  function automatic logic [1:0] first_low(input logic [3:0] r);
    casez (r)
      4'b???0: first_low = 2'd0;
      4'b??01: first_low = 2'd1;
      4'b?011: first_low = 2'd2;
      4'b0111: first_low = 2'd3;
      default: first_low = 2'd0;
    endcase
  endfunction

  logic [3:0]    row_meta_r, row_sync_r;
  logic [DW-1:0] dwell_r;
  logic [1:0]    col_idx_r;
  logic          eval_r;
  logic [1:0]    hit_cnt_r;    // 0 = NONE, 1 = SINGLE, 2 = MULTI (saturated)
  logic [3:0]    hit_code_r;
  logic [1:0]    base_cnt_s, sample_cnt_s;
  logic [3:0]    base_code_s, sample_code_s;
  logic [2:0]    zeros_s, sum_s;

  state_t        state_r;
  logic [SW-1:0] stable_cnt_r, rel_cnt_r, stable_inc_s, rel_inc_s, stable_next_s;
  logic          prev_single_r;
  logic [3:0]    prev_code_r;
`ifdef KEYPAD_REPEAT_EN
  logic [RW-1:0] rep_cnt_r, rep_next_s, rep_target_s;
  logic          rep_first_r;
`endif

  // Fold the current column's sample into the running frame result; column 0 starts a fresh frame.
  always_comb begin
    zeros_s     = zero_count(row_sync_r);
    base_cnt_s  = (col_idx_r == 2'd0) ? 2'd0 : hit_cnt_r;
    base_code_s = (col_idx_r == 2'd0) ? 4'h0 : hit_code_r;
    sum_s       = {1'b0, base_cnt_s} + zeros_s;
    if (sum_s > 3'd2) begin
      sample_cnt_s = 2'd2;
    end else begin
      sample_cnt_s = sum_s[1:0];
    end
    if (base_cnt_s == 2'd0 && zeros_s == 3'd1) begin
      sample_code_s = key_map(first_low(row_sync_r), col_idx_r);
    end else begin
      sample_code_s = base_code_s;
    end
  end

  // Row synchronizer, column dwell timer and per-frame intersection accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_r <= 4'b1111;
      row_sync_r <= 4'b1111;
      dwell_r    <= '0;
      col_idx_r  <= 2'd0;
      col        <= 4'b1110;
      eval_r     <= 1'b0;
      hit_cnt_r  <= 2'd0;
      hit_code_r <= 4'h0;
    end else begin
      row_meta_r <= row;
      row_sync_r <= row_meta_r;
      eval_r     <= 1'b0;
      if (dwell_r == DWELL_LAST) begin
        dwell_r    <= '0;
        col_idx_r  <= col_idx_r + 2'd1;
        col        <= ~(4'b0001 << (col_idx_r + 2'd1));
        hit_cnt_r  <= sample_cnt_s;
        hit_code_r <= sample_code_s;
        eval_r     <= (col_idx_r == 2'd3);
      end else begin
        dwell_r <= dwell_r + DW'(1);
      end
    end
  end

  // Saturating counter increments and the IDLE_WAIT press-stability update.
  always_comb begin
    stable_inc_s = (stable_cnt_r >= DEB_MAX) ? DEB_MAX : stable_cnt_r + SW'(1);
    rel_inc_s    = (rel_cnt_r >= DEB_MAX) ? DEB_MAX : rel_cnt_r + SW'(1);
    if (hit_cnt_r == 2'd1) begin
      if (prev_single_r && prev_code_r == hit_code_r) begin
        stable_next_s = stable_inc_s;
      end else begin
        stable_next_s = SW'(1);
      end
    end else begin
      stable_next_s = SW'(0);
    end
`ifdef KEYPAD_REPEAT_EN
    rep_next_s   = rep_cnt_r + RW'(1);
    rep_target_s = rep_first_r ? RW'(REPEAT_DELAY_FRAMES) : RW'(REPEAT_RATE_FRAMES);
`endif
  end

  // Debounce FSM, evaluated once per frame on the cycle after column 3 is sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE_WAIT;
      stable_cnt_r  <= '0;
      rel_cnt_r     <= '0;
      prev_single_r <= 1'b0;
      prev_code_r   <= 4'h0;
      key_code      <= 4'h0;
      key_valid     <= 1'b0;
      key_held      <= 1'b0;
      multi_key     <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_r     <= '0;
      rep_first_r   <= 1'b1;
`endif
    end else begin
      key_valid <= 1'b0;
      if (eval_r) begin
        multi_key     <= (hit_cnt_r == 2'd2);
        prev_single_r <= (hit_cnt_r == 2'd1);
        prev_code_r   <= hit_code_r;
        case (state_r)
          IDLE_WAIT: begin
            stable_cnt_r <= stable_next_s;
            rel_cnt_r    <= '0;
            if (stable_next_s == DEB_MAX) begin
              key_code  <= hit_code_r;
              key_valid <= 1'b1;
              key_held  <= 1'b1;
              state_r   <= HELD;
`ifdef KEYPAD_REPEAT_EN
              rep_cnt_r   <= '0;
              rep_first_r <= 1'b1;
`endif
            end
          end
          HELD: begin
            if (hit_cnt_r == 2'd0 && rel_inc_s == DEB_MAX) begin
              key_held     <= 1'b0;
              state_r      <= IDLE_WAIT;
              stable_cnt_r <= '0;
              rel_cnt_r    <= '0;
`ifdef KEYPAD_REPEAT_EN
              rep_cnt_r   <= '0;
              rep_first_r <= 1'b1;
`endif
            end else begin
              rel_cnt_r <= (hit_cnt_r == 2'd0) ? rel_inc_s : SW'(0);
`ifdef KEYPAD_REPEAT_EN
              if (rep_next_s == rep_target_s) begin
                key_valid   <= 1'b1;
                rep_cnt_r   <= '0;
                rep_first_r <= 1'b0;
              end else begin
                rep_cnt_r <= rep_next_s;
              end
`endif
            end
          end
          default: begin
            state_r  <= IDLE_WAIT;
            key_held <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
